// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: FSM encoding, fill byte default, bit-count width
// and a bit-order helper used for LSB-first transfers.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;
    localparam int         BITCNT_W      = 4;
    localparam logic [BITCNT_W-1:0] BITS_PER_BYTE = BITCNT_W'(8);

    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus an edge register that
// turns transitions of the synchronized level into single-cycle rise/fall flags.
module spi_slave_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];
    assign rise     = chain[SYNC_STAGES-1] & ~prev;
    assign fall     = ~chain[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave clocked entirely by the system clock: oversamples ss/sck/din,
// shifts one byte per frame with a 1-entry TX holding register and an RX data register.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = SPI_FILL_BYTE
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       mlb,
    input  logic       ss,
    input  logic       sck,
    input  logic       din,
    output logic       dout,
    output logic       dout_oe,
    input  logic [7:0] tdat,
    input  logic       twr,
    output logic       tfull,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rrd,
    output logic       done,
    output logic       ovr,
    output logic       udr
);

    logic ss_s, ss_rise, ss_fall;
    logic sck_s, sck_rise, sck_fall;
    logic din_s, din_rise, din_fall;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk      (clk),
        .rstb     (rstb),
        .async_in (ss),
        .sync_out (ss_s),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk      (clk),
        .rstb     (rstb),
        .async_in (sck),
        .sync_out (sck_s),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk      (clk),
        .rstb     (rstb),
        .async_in (din),
        .sync_out (din_s),
        .rise     (din_rise),
        .fall     (din_fall)
    );

    // Only the edge flags of ss/sck and the level of din drive the datapath.
    logic unused_sync;
    assign unused_sync = ^{ss_s, sck_s, din_rise, din_fall};

    spi_state_t          state;
    logic [BITCNT_W-1:0] bitcnt;
    logic [7:0]          holding;
    logic [7:0]          tx_sh;
    logic [7:0]          rx_sh;
    logic                mlb_q;

    logic [7:0] load_byte;
    logic [7:0] tx_init;
    logic [7:0] rx_next;
    logic       wr_accept;
    logic       complete;

    always_comb begin
        load_byte = tfull ? holding : FILL_BYTE;
        tx_init   = mlb ? load_byte : bit_reverse(load_byte);
        rx_next   = {rx_sh[6:0], din_s};
        wr_accept = twr & ~tfull;
        complete  = (state == ST_SHIFT) && !ss_rise && sck_rise &&
                    (bitcnt == BITS_PER_BYTE - BITCNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state   <= ST_IDLE;
            bitcnt  <= '0;
            mlb_q   <= 1'b1;
            dout    <= 1'b1;
            dout_oe <= 1'b0;
            tfull   <= 1'b0;
            rdata   <= 8'h00;
            rvalid  <= 1'b0;
            done    <= 1'b0;
            ovr     <= 1'b0;
            udr     <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ss_rise) begin
                        state   <= ST_IDLE;
                        dout_oe <= 1'b0;
                        dout    <= 1'b1;
                        bitcnt  <= '0;
                    end else begin
                        state   <= ST_SHIFT;
                        tx_sh   <= tx_init;
                        dout    <= tx_init[7];
                        dout_oe <= 1'b1;
                        mlb_q   <= mlb;
                        bitcnt  <= '0;
                        if (tfull) begin
                            tfull <= 1'b0;
                        end else begin
                            udr <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state   <= ST_IDLE;
                        dout_oe <= 1'b0;
                        dout    <= 1'b1;
                        bitcnt  <= '0;
                    end else if (sck_rise && bitcnt < BITS_PER_BYTE) begin
                        rx_sh  <= rx_next;
                        bitcnt <= bitcnt + BITCNT_W'(1);
                    end else if (sck_fall) begin
                        // First bit was already presented in LOAD, so a fall before
                        // any rise (ss fell with sck high) must not advance the TX shifter.
                        if (bitcnt == BITS_PER_BYTE) begin
                            state <= ST_LOAD;
                        end else if (bitcnt != '0) begin
                            tx_sh <= {tx_sh[6:0], 1'b0};
                            dout  <= tx_sh[6];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (rrd) begin
                rvalid <= 1'b0;
                ovr    <= 1'b0;
            end
            // A completing byte wins over a coincident read acknowledge.
            if (complete) begin
                rdata  <= mlb_q ? rx_next : bit_reverse(rx_next);
                rvalid <= 1'b1;
                done   <= 1'b1;
                ovr    <= rvalid & ~rrd;
            end

            // Host write lands after any same-cycle LOAD has taken the old holding state.
            if (wr_accept) begin
                holding <= tdat;
                tfull   <= 1'b1;
                udr     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master drives the pins while
// host-side strobes and expected values are applied step by step.
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rstb, mlb, ss, sck, din;
    logic       dout, dout_oe;
    logic [7:0] tdat;
    logic       twr, tfull;
    logic [7:0] rdata;
    logic       rvalid, rrd, done, ovr, udr;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(SYNC), .FILL_BYTE(8'hFF)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .mlb     (mlb),
        .ss      (ss),
        .sck     (sck),
        .din     (din),
        .dout    (dout),
        .dout_oe (dout_oe),
        .tdat    (tdat),
        .twr     (twr),
        .tfull   (tfull),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rrd     (rrd),
        .done    (done),
        .ovr     (ovr),
        .udr     (udr)
    );

    always @(posedge clk) begin
        if (!rstb) done_cnt <= 0;
        else if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic host_write(input logic [7:0] b);
        tdat = b;
        twr  = 1'b1;
        wait_n(1);
        twr  = 1'b0;
    endtask

    task automatic host_read();
        rrd = 1'b1;
        wait_n(1);
        rrd = 1'b0;
    endtask

    task automatic ss_low();
        ss = 1'b0;
        wait_n(HALF);
    endtask

    task automatic ss_high();
        wait_n(HALF);
        ss = 1'b1;
        wait_n(HALF);
    endtask

    // Shifts nbits of a byte; miso is assembled in the same bit order as mosi is sent.
    task automatic xfer(input logic [7:0] mosi, input logic msb, input logic rrd_race,
                        input int nbits, output logic [7:0] miso, output logic first);
        int idx;
        miso  = 8'h00;
        first = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            idx = msb ? 7 - i : i;
            din = mosi[idx];
            wait_n(HALF);
            miso[idx] = dout;
            if (i == 0) first = dout;
            sck = 1'b1;
            if (rrd_race && i == 7) begin
                wait_n(SYNC);
                rrd = 1'b1;
                wait_n(1);
                rrd = 1'b0;
                wait_n(HALF - SYNC - 1);
            end else begin
                wait_n(HALF);
            end
            sck = 1'b0;
        end
    endtask

    logic [7:0] m0, m1, m2;
    logic       fb;
    int         dc;

    initial begin
        rstb = 1'b0; mlb = 1'b1; ss = 1'b0; sck = 1'b0; din = 1'b0;
        tdat = 8'h00; twr = 1'b0; rrd = 1'b0;

        // 1: reset with ss low and sck toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sck = ~sck;
        end
        wait_n(1);
        chk("rst_dout", {7'b0, dout}, 8'h01);
        chk("rst_dout_oe", {7'b0, dout_oe}, 8'h00);
        chk("rst_tfull", {7'b0, tfull}, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rvalid", {7'b0, rvalid}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        chk("rst_ovr", {7'b0, ovr}, 8'h00);
        chk("rst_udr", {7'b0, udr}, 8'h00);
        ss = 1'b1; sck = 1'b0;
        wait_n(4);
        rstb = 1'b1;
        wait_n(4);

        // 2: single byte, MSB first
        host_write(8'hA5);
        chk("t2_tfull_set", {7'b0, tfull}, 8'h01);
        dc = done_cnt;
        ss_low();
        chk("t2_dout_oe", {7'b0, dout_oe}, 8'h01);
        xfer(8'h3C, 1'b1, 1'b0, 8, m0, fb);
        ss_high();
        chk("t2_miso", m0, 8'hA5);
        chk("t2_rdata", rdata, 8'h3C);
        chk("t2_done_cnt", 8'(done_cnt - dc), 8'h01);
        chk("t2_rvalid", {7'b0, rvalid}, 8'h01);
        chk("t2_tfull", {7'b0, tfull}, 8'h00);
        chk("t2_udr_trailing_load", {7'b0, udr}, 8'h01);
        chk("t2_oe_off", {7'b0, dout_oe}, 8'h00);
        chk("t2_dout_idle", {7'b0, dout}, 8'h01);
        host_read();
        chk("t2_rvalid_clr", {7'b0, rvalid}, 8'h00);

        // 3: back-to-back bytes, holding reloaded only once
        host_write(8'h10);
        chk("t3_udr_clr", {7'b0, udr}, 8'h00);
        dc = done_cnt;
        ss_low();
        xfer(8'h01, 1'b1, 1'b0, 8, m0, fb);
        host_write(8'h20);
        chk("t3_ovr_b1", {7'b0, ovr}, 8'h00);
        xfer(8'h02, 1'b1, 1'b0, 8, m1, fb);
        chk("t3_ovr_b2", {7'b0, ovr}, 8'h01);
        xfer(8'h03, 1'b1, 1'b0, 8, m2, fb);
        chk("t3_udr_b3", {7'b0, udr}, 8'h01);
        ss_high();
        chk("t3_miso0", m0, 8'h10);
        chk("t3_miso1", m1, 8'h20);
        chk("t3_miso2", m2, 8'hFF);
        chk("t3_rdata", rdata, 8'h03);
        chk("t3_done_cnt", 8'(done_cnt - dc), 8'h03);
        host_read();
        chk("t3_ovr_clr", {7'b0, ovr}, 8'h00);
        chk("t3_rvalid_clr", {7'b0, rvalid}, 8'h00);

        // 4: LSB first
        mlb = 1'b0;
        host_write(8'h01);
        ss_low();
        xfer(8'h80, 1'b0, 1'b0, 8, m0, fb);
        ss_high();
        mlb = 1'b1;
        chk("t4_first_bit", {7'b0, fb}, 8'h01);
        chk("t4_miso", m0, 8'h01);
        chk("t4_rdata", rdata, 8'h80);
        host_read();

        // 5: abort after 5 rises, then a full byte
        dc = done_cnt;
        ss_low();
        xfer(8'hE7, 1'b1, 1'b0, 5, m0, fb);
        wait_n(HALF);
        ss = 1'b1;
        wait_n(SYNC + 1);
        chk("t5_oe_off", {7'b0, dout_oe}, 8'h00);
        chk("t5_dout_idle", {7'b0, dout}, 8'h01);
        wait_n(HALF);
        chk("t5_no_done", 8'(done_cnt - dc), 8'h00);
        chk("t5_rdata_kept", rdata, 8'h80);
        ss_low();
        xfer(8'h55, 1'b1, 1'b0, 8, m0, fb);
        ss_high();
        chk("t5_rdata_next", rdata, 8'h55);
        chk("t5_done_next", 8'(done_cnt - dc), 8'h01);

        // 6: twr coincident with LOAD, rrd coincident with completion
        chk("t6_tfull_pre", {7'b0, tfull}, 8'h00);
        ss = 1'b0;
        wait_n(SYNC + 1);
        tdat = 8'h77;
        twr  = 1'b1;
        wait_n(1);
        twr  = 1'b0;
        chk("t6_tfull_post", {7'b0, tfull}, 8'h01);
        wait_n(HALF - SYNC - 2);
        xfer(8'hC3, 1'b1, 1'b1, 8, m0, fb);
        chk("t6_rvalid_race", {7'b0, rvalid}, 8'h01);
        chk("t6_ovr_race", {7'b0, ovr}, 8'h00);
        chk("t6_rdata_race", rdata, 8'hC3);
        xfer(8'h00, 1'b1, 1'b0, 8, m1, fb);
        ss_high();
        chk("t6_miso_fill", m0, 8'hFF);
        chk("t6_miso_held", m1, 8'h77);
        chk("t6_rdata_last", rdata, 8'h00);
        chk("t6_ovr_last", {7'b0, ovr}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
